// File: rtl/b12_pkg.sv
// Shared definitions for the b12 autoplayer: game geometry, colour codes,
// key/colour conversion helpers and the player state enum.
package b12_pkg;

   localparam int SIZE_ADDRESS = 5;
   localparam int SIZE_MEM     = 2 ** SIZE_ADDRESS;
   localparam int COD_COLOR    = 2;
   localparam int NUM_KEY      = 4;
   localparam int TIMEOUT      = 255;
   localparam int WD_WIDTH     = 8;
   localparam int LEVEL_WIDTH  = SIZE_ADDRESS + 1;

   localparam logic [COD_COLOR-1:0] RED    = 2'd0;
   localparam logic [COD_COLOR-1:0] GREEN  = 2'd1;
   localparam logic [COD_COLOR-1:0] YELLOW = 2'd2;
   localparam logic [COD_COLOR-1:0] BLUE   = 2'd3;

   localparam logic [WD_WIDTH-1:0]     WD_LIMIT   = WD_WIDTH'(TIMEOUT);
   localparam logic [SIZE_ADDRESS-1:0] LAST_ROUND = SIZE_ADDRESS'(SIZE_MEM - 1);
   localparam logic [LEVEL_WIDTH-1:0]  LEVEL_WIN  = LEVEL_WIDTH'(SIZE_MEM);
   localparam logic [NUM_KEY-1:0]      ALL_LEDS   = '1;

   typedef enum logic [3:0] {
      IDLE,
      START,
      OBS_ON,
      OBS_OFF,
      RESP_PRESS,
      RESP_OFF,
      WAIT_WIN,
      WIN,
      LOST,
      ERR
   } state_t;

   function automatic logic [NUM_KEY-1:0] onehot(input logic [COD_COLOR-1:0] color);
      logic [NUM_KEY-1:0] keys;
      keys        = '0;
      keys[color] = 1'b1;
      return keys;
   endfunction

   function automatic logic [COD_COLOR-1:0] encode(input logic [NUM_KEY-1:0] keys);
      logic [COD_COLOR-1:0] color;
      color = RED;
      for (int i = 0; i < NUM_KEY; i++) begin
         if (keys[i]) color = COD_COLOR'(i);
      end
      return color;
   endfunction

endpackage

// File: rtl/b12_seq_store.sv
// Colour sequence memory: one colour code per step of the current round,
// written synchronously, read combinationally, wiped by reset.
module b12_seq_store
   import b12_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    we_i,
   input  logic [SIZE_ADDRESS-1:0] waddr_i,
   input  logic [COD_COLOR-1:0]    wdata_i,
   input  logic [SIZE_ADDRESS-1:0] raddr_i,
   output logic [COD_COLOR-1:0]    rdata_o
);

   logic [COD_COLOR-1:0] mem_q [SIZE_MEM];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < SIZE_MEM; i++) begin
            mem_q[i] <= RED;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/b12_autoplayer.sv
// Automatic b12 player: learns each round from LED playback, replays it on
// the keys, and flags win, loss or protocol errors.
module b12_autoplayer
   import b12_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   go,
   input  logic                   inject_err,
   input  logic [NUM_KEY-1:0]     nl,
   input  logic                   nloss,
   input  logic                   speaker,
   output logic                   start,
   output logic [NUM_KEY-1:0]     k,
   output logic [SIZE_ADDRESS:0]  level,
   output logic                   won,
   output logic                   lost,
   output logic                   err
);

   state_t                  state_q, state_d;
   logic                    start_q, start_d;
   logic [NUM_KEY-1:0]      k_q, k_d;
   logic [LEVEL_WIDTH-1:0]  level_q, level_d;
   logic                    won_q, won_d;
   logic                    lost_q, lost_d;
   logic                    err_q, err_d;
   logic [SIZE_ADDRESS-1:0] round_q, round_d;
   logic [SIZE_ADDRESS-1:0] idx_q, idx_d;
   logic [WD_WIDTH-1:0]     wd_q, wd_d;
   logic [COD_COLOR-1:0]    pressColor_q, pressColor_d;
   logic [NUM_KEY-1:0]      nlPrev_q;
   logic                    nlossPrev_q;

   logic                    nlRise, nlFall, nlossRise, active;
   logic                    storeWe;
   logic [SIZE_ADDRESS-1:0] storeRaddr;
   logic [COD_COLOR-1:0]    storeRdata, chosenColor;
   logic                    speakerUnused;

   assign speakerUnused = speaker;

   assign nlRise    = (nlPrev_q == '0) && (nl != '0);
   assign nlFall    = (nlPrev_q != '0) && (nl == '0);
   assign nlossRise = nloss && !nlossPrev_q;
   assign active    = state_q inside {OBS_ON, OBS_OFF, RESP_PRESS, RESP_OFF, WAIT_WIN};

   // The next press always reads step 0 (after playback) or the step after idx.
   assign storeRaddr  = (state_q == RESP_OFF) ? idx_q + 1'b1 : '0;
   assign chosenColor = inject_err ? storeRdata + 1'b1 : storeRdata;

   b12_seq_store u_store (
      .clock   (clock),
      .reset   (reset),
      .we_i    (storeWe),
      .waddr_i (idx_q),
      .wdata_i (encode(nl)),
      .raddr_i (storeRaddr),
      .rdata_o (storeRdata)
   );

   always_comb begin
      state_d      = state_q;
      start_d      = 1'b0;
      k_d          = k_q;
      level_d      = level_q;
      won_d        = won_q;
      lost_d       = lost_q;
      err_d        = err_q;
      round_d      = round_q;
      idx_d        = idx_q;
      wd_d         = active ? wd_q + 1'b1 : wd_q;
      pressColor_d = pressColor_q;
      storeWe      = 1'b0;

      if (active && nlossRise) begin
         lost_d  = 1'b1;
         k_d     = '0;
         state_d = LOST;
      end else if (active && state_q != WAIT_WIN && nl == ALL_LEDS) begin
         err_d   = 1'b1;
         k_d     = '0;
         state_d = ERR;
      end else if (active && wd_q == WD_LIMIT) begin
         err_d   = 1'b1;
         k_d     = '0;
         state_d = ERR;
      end else begin
         case (state_q)
            IDLE, WIN, LOST, ERR: begin
               k_d = '0;
               if (go) begin
                  state_d = START;
                  start_d = 1'b1;
                  round_d = '0;
                  idx_d   = '0;
                  level_d = '0;
                  won_d   = 1'b0;
                  lost_d  = 1'b0;
                  err_d   = 1'b0;
               end
            end
            START: state_d = OBS_ON;
            OBS_ON: begin
               if (nlRise) begin
                  if ($onehot(nl)) begin
                     storeWe = 1'b1;
                     state_d = OBS_OFF;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ERR;
                  end
               end
            end
            OBS_OFF: begin
               if (nlFall) begin
                  if (idx_q == round_q) begin
                     idx_d        = '0;
                     pressColor_d = chosenColor;
                     k_d          = onehot(chosenColor);
                     state_d      = RESP_PRESS;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = OBS_ON;
                  end
               end
            end
            RESP_PRESS: begin
               if (nlRise) begin
                  k_d = '0;
                  if (!$onehot(nl) || encode(nl) != pressColor_q) begin
                     err_d   = 1'b1;
                     state_d = ERR;
                  end else begin
                     state_d = RESP_OFF;
                  end
               end
            end
            RESP_OFF: begin
               if (nlFall) begin
                  if (idx_q != round_q) begin
                     idx_d        = idx_q + 1'b1;
                     pressColor_d = chosenColor;
                     k_d          = onehot(chosenColor);
                     state_d      = RESP_PRESS;
                  end else if (round_q == LAST_ROUND) begin
                     level_d = LEVEL_WIN;
                     state_d = WAIT_WIN;
                  end else begin
                     level_d = level_q + 1'b1;
                     round_d = round_q + 1'b1;
                     idx_d   = '0;
                     state_d = OBS_ON;
                  end
               end
            end
            WAIT_WIN: begin
               if (nl == ALL_LEDS) begin
                  won_d   = 1'b1;
                  state_d = WIN;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (state_d != state_q) wd_d = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         start_q      <= 1'b0;
         k_q          <= '0;
         level_q      <= '0;
         won_q        <= 1'b0;
         lost_q       <= 1'b0;
         err_q        <= 1'b0;
         round_q      <= '0;
         idx_q        <= '0;
         wd_q         <= '0;
         pressColor_q <= RED;
         nlPrev_q     <= '0;
         nlossPrev_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         k_q          <= k_d;
         level_q      <= level_d;
         won_q        <= won_d;
         lost_q       <= lost_d;
         err_q        <= err_d;
         round_q      <= round_d;
         idx_q        <= idx_d;
         wd_q         <= wd_d;
         pressColor_q <= pressColor_d;
         nlPrev_q     <= nl;
         nlossPrev_q  <= nloss;
      end
   end

   assign start = start_q;
   assign k     = k_q;
   assign level = level_q;
   assign won   = won_q;
   assign lost  = lost_q;
   assign err   = err_q;

endmodule
